// File: rtl/shift_issue_stage.sv
// Registered issue stage in front of the ALU shifter: decodes shift requests into shifter
// controls and holds them in an output register backed by a one-entry skid buffer.
module shift_issue_stage #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [2:0]       s_op,
   input  logic             s_shsel,
   input  logic [4:0]       s_imm,
   input  logic [31:0]      s_rs,
   input  logic [31:0]      s_data,
   input  logic [TAG_W-1:0] s_tag,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_in,
   output logic [31:0]      m_shamt,
   output logic             m_direction,
   output logic             m_a_or_l,
   output logic             m_err,
   output logic [TAG_W-1:0] m_tag
);

   typedef struct packed {
      logic [31:0]      in;
      logic [31:0]      shamt;
      logic             dir;
      logic             a_or_l;
      logic             err;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_s_ready;
   entry_t      r_out;
   entry_t      r_skid;
   entry_t      w_dec;
   logic [31:0] w_amt;
   logic        w_accept;
   logic        w_pop;
   logic        w_load_out_new;
   logic        w_load_out_skid;
   logic        w_load_skid;

   assign w_amt    = s_shsel ? s_rs : {27'b0, s_imm};
   assign w_accept = s_valid & r_s_ready;
   assign w_pop    = (r_state != ST_EMPTY) & m_ready;

   // Illegal ops pass through with zeroed controls so the shifter returns m_in unchanged.
   always_comb begin
      w_dec     = '0;
      w_dec.in  = s_data;
      w_dec.tag = s_tag;
      case (s_op)
         3'b000: begin
            w_dec.dir   = 1'b1;
            w_dec.shamt = w_amt;
         end
         3'b001: begin
            w_dec.shamt = w_amt;
         end
         3'b010: begin
            w_dec.a_or_l = 1'b1;
            w_dec.shamt  = w_amt;
         end
         default: begin
            w_dec.err = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_next          = r_state;
      w_load_out_new  = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
      if (flush) begin
         w_next = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_load_out_new = 1'b1;
                  w_next         = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_pop) begin
                  w_load_out_new = 1'b1;
               end else if (w_accept) begin
                  w_load_skid = 1'b1;
                  w_next      = ST_FULL;
               end else if (w_pop) begin
                  w_next = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  w_load_out_skid = 1'b1;
                  w_next          = ST_ONE;
               end
            end
            default: begin
               w_next = ST_EMPTY;
            end
         endcase
      end
   end

   // s_ready is registered from the next state, keeping m_ready off any combinational path to it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_EMPTY;
         r_s_ready <= 1'b1;
         r_out     <= '0;
         r_skid    <= '0;
      end else begin
         r_state   <= w_next;
         r_s_ready <= (w_next != ST_FULL);
         if (w_load_out_new) begin
            r_out <= w_dec;
         end else if (w_load_out_skid) begin
            r_out <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_dec;
         end
      end
   end

   assign s_ready     = r_s_ready;
   assign m_valid     = (r_state != ST_EMPTY);
   assign m_in        = r_out.in;
   assign m_shamt     = r_out.shamt;
   assign m_direction = r_out.dir;
   assign m_a_or_l    = r_out.a_or_l;
   assign m_err       = r_out.err;
   assign m_tag       = r_out.tag;

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Registered issue stage directly upstream of the ALU shift unit. Accepts decoded shift requests over a valid/ready handshake. Translates the operation code and shift-amount source into the shifter's control signals `in`, `shamt`, `direction` and `a_or_l`, and holds them in an output register that drives the combinational shifter. A one-entry skid buffer gives full throughput while keeping `s_ready` registered.

## Interface
- `TAG_W`, default 4: width of the opaque request tag carried with each operation.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous flush; discards all held requests.
- `s_valid`  in  1  upstream request valid.
- `s_ready`  out  1  stage can accept; driven from a register.
- `s_op`  in  3  000 SLL, 001 SRL, 010 SRA, others illegal.
- `s_shsel`  in  1  0: immediate amount, 1: register amount.
- `s_imm`  in  5  immediate shift amount.
- `s_rs`  in  32  register shift amount.
- `s_data`  in  32  value to shift.
- `s_tag`  in  TAG_W  request tag.
- `m_valid`  out  1  output register holds a request.
- `m_ready`  in  1  downstream consumes.
- `m_in`  out  32  drives shifter `in`.
- `m_shamt`  out  32  drives shifter `shamt`.
- `m_direction`  out  1  1 = left, 0 = right.
- `m_a_or_l`  out  1  1 = arithmetic, 0 = logical.
- `m_err`  out  1  request had an illegal op.
- `m_tag`  out  TAG_W  tag of the held request.

## Operation
- **Decode:**
  - SLL gives direction 1, a_or_l 0.
  - SRL gives direction 0, a_or_l 0.
  - SRA gives direction 0, a_or_l 1.
  - The stage never emits direction 1 with a_or_l 1.
- **Amount:**
  - `s_shsel` = 0 gives `{27'b0, s_imm}`.
  - `s_shsel` = 1 passes `s_rs` unmodified, all 32 bits. Amounts of 32 or more reach the shifter as-is and yield 0 or sign fill.
- **Illegal op:**
  - Request is accepted and carried through with err = 1.
  - Controls become direction 0, a_or_l 0, shamt 0, so the shifter output equals `m_in`.
- **Storage:** output register (OUT) plus skid register (SKID), each holding decoded in, shamt, direction, a_or_l, err and tag.
- **Events:** accept = `s_valid & s_ready`; pop = `m_valid & m_ready`.
- **States:**
  - **EMPTY:** accept → load OUT, go to ONE.
  - **ONE:**
    - accept & pop → load OUT with new request, stay ONE.
    - accept & !pop → load SKID, go to FULL.
    - !accept & pop → EMPTY.
    - otherwise hold.
  - **FULL:**
    - `s_ready` = 0.
    - pop → OUT loads from SKID, go to ONE.
    - otherwise hold.
- **Readiness and ordering:**
  - `s_ready` = 1 in EMPTY and ONE, 0 in FULL; registered with the state.
  - Order is strictly FIFO: the SKID entry is always older than any later request.
- **Flush:**
  - Has priority over all events; next state is EMPTY.
  - An accept in the flush cycle counts as consumed by upstream and is discarded.
- **Stability:** while `m_valid` = 1 and `m_ready` = 0, all `m_*` outputs are held stable.

## Timing
- **Reset:**
  - Asynchronous; state goes to EMPTY immediately.
  - `m_valid` = 0, `s_ready` = 1.
  - `m_in`, `m_shamt`, `m_direction`, `m_a_or_l`, `m_err`, `m_tag` all = 0; SKID = 0.
  - Reset mid-transfer drops all held requests.
- **Latency:** a request accepted at edge N appears on `m_*` with `m_valid` = 1 after edge N; the shifter result is valid in that same cycle.
- **Throughput:** one request per cycle while `m_ready` = 1.
- **Backpressure:** after a `m_ready` = 0 cycle, at most one extra request is absorbed, then `s_ready` deasserts at the next edge.
- **FULL recovery:** a pop in FULL restores `s_ready` = 1 in the following cycle; there is no combinational path from `m_ready` to `s_ready`.
- **Unchanged outputs:** `m_*` data changes only on a load of OUT.

## Test plan
- **Reset:** assert `rst` mid-cycle with OUT and SKID full → `m_valid` = 0, `s_ready` = 1, all `m_*` = 0 before the next edge.
- **Streaming:** `m_ready` = 1; issue SLL imm 4 on 0x0000_00F0, SRL reg 0x24 on 0x8000_0000, SRA imm 31 on 0x8000_0000 back-to-back. Expect, one per cycle in order:
  - dir 1, a_or_l 0, shamt 4;
  - dir 0, a_or_l 0, shamt 0x24;
  - dir 0, a_or_l 1, shamt 31.
- **Backpressure:** drop `m_ready` while streaming tags 1,2,3.
  - Tag 1 is held on `m_*` with `m_valid` = 1.
  - Tag 2 is absorbed into SKID; `s_ready` = 0 and tag 3 is held upstream.
  - Raise `m_ready` → tags 1, 2, 3 emerge in order with no loss or duplication.
- **Illegal op:** op 101, data 0x1234_5678 → `m_err` = 1, dir 0, a_or_l 0, shamt 0, shifter output 0x1234_5678.
- **Flush in FULL with concurrent `s_valid`** → next cycle `m_valid` = 0, `s_ready` = 1; no flushed tag ever appears.
- **Register amount with upper bits set:** `s_rs` = 0xFFFF_FFE3 → `m_shamt` = 0xFFFF_FFE3, not truncated.
